multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the single-cycle decode/datapath.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Shares one memory port between instruction fetch and load/store using a req/ack handshake.
- Gates the decoder's register-write and PC-update controls so each takes effect exactly once per instruction. Detects BREAK (halt) and memory timeouts (fault).

Parameters:
- WAIT_MAX, 15: maximum wait cycles with mem_req high and no mem_ack before FAULT.
- W_WAIT, 4: width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/continue; sampled in IDLE and at WB.
- dec_mem_cmd  in  `W_MEM_CMD  mem_cmd from the decoder.
- dec_reg_wen  in  1  reg_wen from the decoder.
- dec_pc_src  in  `W_PC_SRC  pc_src from the decoder.
- dec_alu_op  in  `W_FUNCT  alu_op from the decoder.
- mem_ack  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result).
- mem_we  out  1  write strobe for a data store.
- ir_wen  out  1  latch fetched word into the instruction register.
- pc_wen  out  1  update the PC.
- pc_sel  out  `W_PC_SRC  PC mux select, valid while pc_wen is high.
- reg_wen  out  1  gated register-file write enable.
- halted  out  1  BREAK executed.
- fault  out  1  memory timeout.
- state  out  3  current state, for debug.
- instr_cnt  out  `W_CPU  retired-instruction count.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Output style: all outputs are Moore decodes of the registered state, except ir_wen, which is Mealy (FETCH & mem_ack).
- Reset: on rst high at a clk edge, state=IDLE, wait_cnt=0, instr_cnt=0.
  - All outputs are 0 after that edge.
  - rst overrides every transition, including mid-FETCH/MEM; an outstanding request is simply dropped.
- IDLE: all strobes 0. run=1 → FETCH.
- FETCH: mem_req=1, mem_sel=0, mem_we=0.
  - mem_ack=1 → ir_wen=1 in the same cycle, then → DECODE.
  - No ack → stay and increment wait_cnt.
- DECODE: one cycle; decoder outputs settle from the new IR.
  - dec_alu_op==`F_BREAK → HALT.
  - Otherwise → EXEC.
- EXEC: one cycle; ALU result settles.
  - dec_mem_cmd != `MEM_NOP → MEM.
  - Otherwise → WB.
- MEM: mem_req=1, mem_sel=1, mem_we=(dec_mem_cmd==`MEM_WRITE).
  - mem_ack → WB; otherwise stay and increment wait_cnt.
- WB: one cycle.
  - reg_wen=dec_reg_wen, pc_wen=1, pc_sel=dec_pc_src.
  - instr_cnt increments at the exit edge, wrapping at 2^`W_CPU.
  - run=1 → FETCH; run=0 → IDLE.
- HALT: halted=1, all strobes 0. Terminal until rst; run is ignored.
- FAULT: fault=1, all strobes 0. Terminal until rst.
- Timeout:
  - wait_cnt clears on entry to FETCH and to MEM.
  - In FETCH/MEM with mem_ack=0 and wait_cnt==WAIT_MAX → FAULT. Fault therefore occurs after WAIT_MAX+1 unacked request cycles.
  - mem_ack in the same cycle as the limit wins: normal transition, no fault.
- mem_ack outside FETCH/MEM is ignored.
- reg_wen, pc_wen and ir_wen are never high outside WB, WB and FETCH respectively.
- Zero-wait memory cycle counts: ALU/branch/jump instruction = 4 cycles (F, D, E, W); load/store = 5 cycles.
- SYSCALL has no special handling: it passes EXEC→WB with reg_wen=0 as supplied by the decoder.

Decomposition:
- Shared include lib/ctrl.v holds:
  - `W_STATE (3) and the state macros `S_IDLE … `S_FAULT, shared with the debug printer and testbench.
  - Opcode/funct/mem_cmd macros, taken from the existing opcode header.
- Sub-module mem_wait_timer:
  - Inputs: clk, rst, clear, count_en.
  - Output: expired = (cnt==WAIT_MAX) & count_en.
  - Instantiated once and shared by FETCH and MEM.

Test Plan:
- ADDI, run=1, ack every request cycle → state 0,1,2,3,5,1; reg_wen=1 and pc_wen=1 only in cycle 4; instr_cnt=1 after 4 cycles.
- LW with fetch ack after 2 waits and MEM ack after 1 wait → 1,1,1,2,3,4,4,5; mem_sel=1, mem_we=0 in MEM; reg_wen=1 in WB; total 8 cycles.
- SW, zero-wait → mem_we=1 for exactly 1 cycle in MEM; reg_wen=0 and pc_wen=1 in WB; total 5 cycles.
- BREAK instruction → HALT after DECODE; halted=1; no pc_wen/reg_wen; held through 20 cycles with run=1 and mem_ack toggling; instr_cnt unchanged.
- WAIT_MAX=3, mem_ack held 0 in FETCH → FAULT after 4 request cycles. Repeat with ack in the 4th cycle → DECODE, no fault.
- rst pulsed while in MEM with mem_req high → next cycle state=0, mem_req=0, instr_cnt=0. run=0 at WB → IDLE, no further mem_req.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding,
// decoder field widths and the opcode/funct/mem_cmd values it reacts to.
// Pure declarations; no logic, no latency, no flow control.
package multicycle_ctrl_pkg;

  localparam int W_STATE   = 3;
  localparam int W_MEM_CMD = 2;
  localparam int W_PC_SRC  = 2;
  localparam int W_FUNCT   = 6;
  localparam int W_CPU     = 32;

  // Encoding is visible on the debug port, so the values are fixed.
  typedef enum logic [W_STATE-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
  localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
  localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

  localparam logic [W_FUNCT-1:0] F_SYSCALL = 6'h0c;
  localparam logic [W_FUNCT-1:0] F_BREAK   = 6'h0d;
  localparam logic [W_FUNCT-1:0] F_ADD     = 6'h20;

  // States that drive a request onto the shared memory port.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts unacknowledged memory request cycles; flags the cycle that hits the limit.
// Latency: expired is combinational from the registered count and count_en.
// Backpressure: none; clear has priority over counting.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - zero the count (asserted on entry to a request state)
//   count_en  - request outstanding and not acknowledged this cycle
//   expired   - count_en while the count already equals WAIT_MAX
module mem_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int W_WAIT   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [W_WAIT-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = count_en && (cnt == W_WAIT'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/[MEM]/WB over one shared memory port.
// Latency: 4 cycles per ALU/branch instruction, 5 per load/store, plus memory waits.
// Backpressure: holds in FETCH/MEM until mem_ack; WAIT_MAX+1 unacked cycles -> FAULT.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   run             - start in IDLE / continue at WB
//   dec_*           - decoder controls for the instruction in the IR
//   mem_ack         - memory completes the current request
//   mem_req/sel/we  - shared memory port request, address select (1=data), store strobe
//   ir_wen          - latch fetched word (FETCH & mem_ack)
//   pc_wen, pc_sel  - PC update strobe and mux select (WB only)
//   reg_wen         - gated register-file write (WB only)
//   halted, fault   - BREAK executed / memory timeout
//   state           - current state for debug
//   instr_cnt       - retired-instruction count
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int W_WAIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
  input  logic                 dec_reg_wen,
  input  logic [W_PC_SRC-1:0]  dec_pc_src,
  input  logic [W_FUNCT-1:0]   dec_alu_op,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_sel,
  output logic                 mem_we,
  output logic                 ir_wen,
  output logic                 pc_wen,
  output logic [W_PC_SRC-1:0]  pc_sel,
  output logic                 reg_wen,
  output logic                 halted,
  output logic                 fault,
  output logic [W_STATE-1:0]   state,
  output logic [W_CPU-1:0]     instr_cnt
);

  state_t cur_state;
  state_t nxt_state;
  logic   wait_clear;
  logic   wait_count_en;
  logic   wait_expired;

  // One timer serves both request states; it is re-armed on every entry.
  assign wait_count_en = is_mem_state(cur_state) && !mem_ack;
  assign wait_clear    = is_mem_state(nxt_state) && (nxt_state != cur_state);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .W_WAIT   (W_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clear),
    .count_en (wait_count_en),
    .expired  (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // WB always lasts exactly one cycle, so counting WB cycles counts retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (cur_state == S_WB) begin
      instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:   if (run) nxt_state = S_FETCH;
      S_FETCH: begin
        if (mem_ack)           nxt_state = S_DECODE;
        else if (wait_expired) nxt_state = S_FAULT;
      end
      S_DECODE: nxt_state = (dec_alu_op == F_BREAK) ? S_HALT : S_EXEC;
      S_EXEC:   nxt_state = (dec_mem_cmd != MEM_NOP) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack)           nxt_state = S_WB;
        else if (wait_expired) nxt_state = S_FAULT;
      end
      S_WB:     nxt_state = run ? S_FETCH : S_IDLE;
      S_HALT:   nxt_state = S_HALT;
      S_FAULT:  nxt_state = S_FAULT;
      default:  nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we  = 1'b0;
    ir_wen  = 1'b0;
    pc_wen  = 1'b0;
    pc_sel  = '0;
    reg_wen = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_wen  = mem_ack;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (dec_mem_cmd == MEM_WRITE);
      end
      S_WB: begin
        pc_wen  = 1'b1;
        pc_sel  = dec_pc_src;
        reg_wen = dec_reg_wen;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign state = cur_state;

endmodule
